// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target with 7-bit address match.
// It receives write bytes and serialises read bytes through an open-drain SDA enable.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sy, sda_sy;
  logic scl_d, sda_d, scl_s, sda_s, rise, fall, start, stop;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, rx_data_n;
  logic rw, rw_n, busy_n, oe_n, rx_valid_n, tx_load_n;
  assign scl_s = scl_sy[SYNC_STAGES-1];
  assign sda_s = sda_sy[SYNC_STAGES-1];
  assign rise = scl_s & ~scl_d;
  assign fall = ~scl_s & scl_d;
  assign start = scl_s & sda_d & ~sda_s;
  assign stop = scl_s & ~sda_d & sda_s;
  // Sync flops idle high so leaving reset never looks like a bus edge.
  always_ff @(posedge ck or negedge reset)
    if (!reset) begin
      scl_sy <= '1;
      sda_sy <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      rw <= 1'b0;
      busy <= 1'b0;
      sda_oe <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_load <= 1'b0;
    end else begin
      scl_sy <= {scl_sy[SYNC_STAGES-2:0], scl_in};
      sda_sy <= {sda_sy[SYNC_STAGES-2:0], sda_in};
      scl_d <= scl_s;
      sda_d <= sda_s;
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      rw <= rw_n;
      busy <= busy_n;
      sda_oe <= oe_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_load <= tx_load_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    rw_n = rw;
    busy_n = busy;
    oe_n = sda_oe;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    tx_load_n = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else case (state)
      ADDR, WRITE: if (rise) begin
        sh_n = {sh[6:0], sda_s};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
          if (state == WRITE) begin
            rx_data_n = sh_n;
            rx_valid_n = 1'b1;
            state_n = ACK_WR;
          end else if (sh[6:0] == DEV_ADDR) begin
            rw_n = sda_s;
            busy_n = 1'b1;
            state_n = ACK_ADDR;
          end else begin
            busy_n = 1'b0;
            state_n = IGNORE;
          end
        end
      end
      // The ACK slot's first fall asserts the pull, the second ends the slot.
      ACK_ADDR, ACK_WR: if (fall) begin
        oe_n = ~sda_oe;
        cnt_n = '0;
        if (sda_oe) begin
          state_n = (state == ACK_WR || !rw) ? WRITE : READ;
          if (state == ACK_ADDR && rw) begin
            sh_n = tx_data;
            tx_load_n = 1'b1;
            oe_n = ~tx_data[7];
          end
        end
      end
      READ: if (fall) begin
        cnt_n = cnt + 3'd1;
        sh_n = {sh[6:0], 1'b0};
        oe_n = (cnt == 3'd7) ? 1'b0 : ~sh[6];
        state_n = (cnt == 3'd7) ? ACK_RD : READ;
      end
      ACK_RD: if (rise && sda_s) state_n = IGNORE;
        else if (fall) begin
          sh_n = tx_data;
          tx_load_n = 1'b1;
          oe_n = ~tx_data[7];
          cnt_n = '0;
          state_n = READ;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master with a byte-level model of what the target must do.
module tb_i2c_target;
  localparam logic [6:0] DEV = 7'h50;
  logic ck = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_pad, sda_oe, rx_valid, tx_load, busy;
  logic [7:0] rx_data, tx_data = 8'h00;
  assign sda_pad = sda_m & ~sda_oe;
  i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .ck(ck), .reset(reset), .scl_in(scl_m), .sda_in(sda_pad), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load), .busy(busy)
  );
  always #5 ck = ~ck;

  int n_chk = 0, n_fail = 0;
  logic oe_chk = 1'b0, st_chk = 1'b0, exp_oe = 1'b0, exp_busy = 1'b0;
  logic [7:0] exp_rx = 8'h00;
  logic [7:0] dut_rxq[$], exp_rxq[$];
  int n_txl = 0, exp_txl = 0;
  logic prev_rxv = 1'b0, prev_txl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (oe_chk) check("sda_oe", 32'(sda_oe), 32'(exp_oe));
    if (st_chk) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("rx_data", 32'(rx_data), 32'(exp_rx));
    end
    if (rx_valid) begin
      check("rx_valid_width", 32'(prev_rxv), 32'd0);
      dut_rxq.push_back(rx_data);
    end
    if (tx_load) begin
      check("tx_load_width", 32'(prev_txl), 32'd0);
      n_txl++;
    end
    prev_rxv = rx_valid;
    prev_txl = tx_load;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ck);
  endtask

  // One SCL period starting and ending with SCL low; pull = target must hold SDA low while SCL is high.
  task automatic clock_bit(input logic b, input logic pull, output logic seen);
    st_chk = 1'b1;
    cyc(int'($urandom_range(4, 3)));
    sda_m = b;
    cyc(int'($urandom_range(4, 2)));
    st_chk = 1'b0;
    scl_m = 1'b1;
    exp_oe = pull;
    oe_chk = 1'b1;
    cyc(int'($urandom_range(8, 5)));
    seen = sda_pad;
    scl_m = 1'b0;
    oe_chk = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl_m) begin
      cyc(3);
      sda_m = 1'b1;
      cyc(3);
      scl_m = 1'b1;
    end
    cyc(5);
    sda_m = 1'b0;
    cyc(5);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    cyc(3);
    sda_m = 1'b0;
    cyc(3);
    scl_m = 1'b1;
    cyc(5);
    sda_m = 1'b1;
    exp_busy = 1'b0;
    cyc(6);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_oe", 32'(sda_oe), 32'd0);
  endtask

  // kind 0: address byte, 1: data written to this target, 2: data nobody acknowledges
  task automatic write_byte(input logic [7:0] d, input int kind);
    logic s, ack;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], 1'b0, s);
    ack = (kind == 0) ? (d[7:1] == DEV) : (kind == 1);
    if (kind == 0) exp_busy = ack;
    if (kind == 1) begin
      exp_rx = d;
      exp_rxq.push_back(d);
    end
    clock_bit(1'b1, ack, s);
    check("ack_seen", 32'(s), 32'(!ack));
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack, input logic [7:0] nxt, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, ~exp[i], s);
      got[i] = s;
    end
    exp_txl++;
    tx_data = nxt;
    clock_bit(~ack, 1'b0, s);
    check("read_byte", 32'(got), 32'(exp));
  endtask

  task automatic score();
    check("rx_count", 32'(dut_rxq.size()), 32'(exp_rxq.size()));
    while (dut_rxq.size() > 0 && exp_rxq.size() > 0)
      check("rx_byte", 32'(dut_rxq.pop_front()), 32'(exp_rxq.pop_front()));
    dut_rxq.delete();
    exp_rxq.delete();
    check("tx_load_count", 32'(n_txl), 32'(exp_txl));
  endtask

  initial begin
    logic [7:0] got, d, nx;
    logic s, rd, m;
    logic [6:0] a;
    int n, txl0;
    cyc(3);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cyc(5);
    start_cond();
    write_byte(8'hA0, 0);
    check("busy_after_match", 32'(busy), 32'd1);
    write_byte(8'hA5, 1);
    stop_cond();
    check("rx_A5", 32'(rx_data), 32'hA5);
    score();
    start_cond();
    write_byte(8'hA2, 0);
    write_byte(8'h11, 2);
    check("busy_other_addr", 32'(busy), 32'd0);
    stop_cond();
    check("rx_kept_A5", 32'(rx_data), 32'hA5);
    score();
    txl0 = n_txl;
    tx_data = 8'h3C;
    start_cond();
    write_byte(8'hA1, 0);
    read_byte(8'h3C, 1'b1, 8'hC3, got);
    check("rd_3C", 32'(got), 32'h3C);
    read_byte(8'hC3, 1'b0, 8'h00, got);
    check("rd_C3", 32'(got), 32'hC3);
    check("busy_after_nack", 32'(busy), 32'd1);
    stop_cond();
    check("two_tx_loads", 32'(n_txl - txl0), 32'd2);
    score();
    start_cond();
    write_byte(8'hA0, 0);
    write_byte(8'h5A, 1);
    tx_data = 8'($urandom);
    d = tx_data;
    start_cond();
    write_byte(8'hA1, 0);
    read_byte(d, 1'b0, d, got);
    stop_cond();
    check("rx_5A", 32'(rx_data), 32'h5A);
    score();
    start_cond();
    write_byte(8'hA0, 0);
    write_byte(8'h33, 1);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), 1'b0, s);
    cyc(2);
    reset = 1'b0;
    #1;
    check("mid_rst_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    exp_busy = 1'b0;
    exp_rx = 8'h00;
    cyc(3);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), 1'b0, s);
    clock_bit(1'b1, 1'b0, s);
    check("no_ack_after_rst", 32'(s), 32'd1);
    stop_cond();
    start_cond();
    write_byte(8'hA0, 0);
    write_byte(8'h77, 1);
    stop_cond();
    check("rx_77", 32'(rx_data), 32'h77);
    score();
    start_cond();
    write_byte(8'hA0, 0);
    for (int i = 0; i < 3; i++) clock_bit(1'($urandom), 1'b0, s);
    stop_cond();
    score();
    for (int t = 0; t < 10; t++) begin
      a = ($urandom_range(1, 0) == 1) ? DEV : 7'($urandom);
      m = (a == DEV);
      rd = 1'($urandom);
      n = int'($urandom_range(3, 1));
      tx_data = 8'($urandom);
      d = tx_data;
      start_cond();
      write_byte({a, rd}, 0);
      for (int i = 0; i < n; i++)
        if (rd && m) begin
          nx = 8'($urandom);
          read_byte(d, i < n - 1, nx, got);
          d = nx;
        end else write_byte(8'($urandom), m ? 1 : 2);
      stop_cond();
      score();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that answers the bus driven by the team's I2C master, which is clocked from the divided phases of the system clock.
- Samples SCL/SDA oversampled on the system clock `ck`.
- Detects START/STOP, matches a 7-bit address and hands received bytes to the user side. On read, it fetches bytes from the user side and serialises them onto SDA.
- Drives SDA open-drain through an output-enable only; the block never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this target responds to
- SYNC_STAGES, 2, synchroniser depth for scl_in/sda_in (legal values 2..3)

Ports:
- ck  input  1  system clock; all flops on posedge ck
- reset  input  1  asynchronous active-low reset; all state cleared while low
- scl_in  input  1  raw SCL pad value
- sda_in  input  1  raw SDA pad value
- sda_oe  output  1  1 = pull SDA low; 0 = release
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-ck pulse when rx_data is updated
- tx_data  input  8  byte to send on a master read
- tx_load  output  1  one-ck pulse in the cycle tx_data is captured
- busy  output  1  high from address match until STOP, or until a START that does not re-address this target

Behaviour:
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, FSM=IDLE, bit counter=0.
- Sync and edge detection:
  - scl_in and sda_in pass through SYNC_STAGES flops each, plus one history flop.
  - Edges are detected on the synced values, giving SYNC_STAGES+1 ck of latency from pad to action.
  - The bus requires SCL high and low phases of at least SYNC_STAGES+3 ck.
- START: synced SDA falls while synced SCL is high. Valid in any state, including mid-byte (repeated START). Action: FSM->ADDR, bit counter=0, sda_oe=0.
- STOP: synced SDA rises while synced SCL is high. Valid in any state. Action: FSM->IDLE, sda_oe=0, busy=0.
- START and STOP take priority over SCL-edge actions in the same cycle.
- FSM states: IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD, IGNORE.
- Bits are shifted MSB first. SDA is sampled on the SCL rising edge; sda_oe changes only on the SCL falling edge.
- ADDR:
  - Shift 8 bits.
  - After the 8th rising edge, compare byte[7:1] to DEV_ADDR.
  - Match: remember the R/W bit, busy=1, and go to ACK_ADDR.
  - Mismatch: go to IGNORE, which waits for START/STOP with sda_oe held at 0.
- ACK_ADDR:
  - At the next SCL fall, set sda_oe=1.
  - At the following SCL fall, sda_oe is released.
  - If R/W=0: go to WRITE.
  - If R/W=1: capture tx_data, pulse tx_load, go to READ, and drive bit7 in the same cycle (sda_oe = ~bit).
- WRITE:
  - Shift 8 bits.
  - On the 8th rising edge: rx_data<=byte, rx_valid=1 for exactly 1 ck, go to ACK_WR.
  - Every byte is ACKed; there is no flow control.
- ACK_WR: same ACK drive as ACK_ADDR (sda_oe=1 at the next SCL fall, released at the following fall), then return to WRITE with counter=0.
- READ:
  - Bit n is presented on each SCL fall as sda_oe = ~bit.
  - After the 8th bit's SCL fall, set sda_oe=0 and go to ACK_RD.
- ACK_RD: sample SDA on the SCL rise.
  - 0 (ACK): at the next SCL fall, capture tx_data, pulse tx_load, drive bit7, go to READ.
  - 1 (NACK): go to IGNORE until STOP/START; busy stays 1 until that event.
- Counter is 3 bits and wraps 7->0 only on the state transition; no other wrap is legal.
- Reset asserted mid-transfer: immediate return to reset values, sda_oe=0 asynchronously. The rest of the transfer is ignored until the next START.
- A START inside ACK_ADDR/ACK_WR while sda_oe=1 releases sda_oe in the same cycle.

Test Plan:
- DEV_ADDR=7'h50: START, 8'hA0, 8'hA5, STOP -> sda_oe=1 during both ACK slots. One rx_valid pulse with rx_data=8'hA5. busy 1->0 after STOP.
- START, 8'hA2, 8'h11, STOP -> sda_oe stays 0 throughout, no rx_valid, busy stays 0.
- START, 8'hA1; tx_data=8'h3C for byte 1; master ACK; tx_data=8'hC3 for byte 2; master NACK; STOP -> SDA carries 0011_1100 then 1100_0011. Exactly 2 tx_load pulses, sda_oe=0 after NACK.
- START, 8'hA0, 8'h5A, repeated START, 8'hA1, read 1 byte, NACK, STOP -> rx_data=8'h5A with one rx_valid, then the read returns the current tx_data. Repeated START lands in ADDR.
- Reset low after 4 bits of a write byte, then release, then a full write of 8'h77 -> outputs at reset values while low, then one rx_valid with rx_data=8'h77.
- STOP injected mid-byte in WRITE after 3 bits -> FSM back to IDLE, no rx_valid, busy=0, sda_oe=0.
